// File: rtl/frodo_mem_pkg.sv
// Shared types for the coefficient-RAM port arbiter: owner encoding, requester id,
// read-tag record and default RAM geometry.
package frodo_mem_pkg;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int NUM_REQ        = 2;

  typedef logic req_id_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_R0, OWN_R1} owner_e;

  typedef struct packed {
    logic    vld;
    req_id_t id;
    logic    is_read;
  } rd_tag_t;

  function automatic owner_e id2owner(req_id_t id);
    return id ? OWN_R1 : OWN_R0;
  endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side bus of the coefficient-RAM arbiter.
// slave = arbiter view, master = requesters plus RAM.
interface ram_port_arbiter_if
  import frodo_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  r0_req, r0_lock, r0_we_a, r0_we_b;
  logic [ADDR_WIDTH-1:0] r0_addr_a, r0_addr_b;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_gnt, r0_rvalid;
  logic [DATA_WIDTH-1:0] r0_rdata_a, r0_rdata_b;

  logic                  r1_req, r1_lock, r1_we_a, r1_we_b;
  logic [ADDR_WIDTH-1:0] r1_addr_a, r1_addr_b;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_gnt, r1_rvalid;
  logic [DATA_WIDTH-1:0] r1_rdata_a, r1_rdata_b;

  logic                  ram_wr_en_a, ram_wr_en_b;
  logic [ADDR_WIDTH-1:0] ram_addr_a, ram_addr_b;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata_a, ram_rdata_b;

  modport slave (
    input  r0_req, r0_lock, r0_we_a, r0_we_b, r0_addr_a, r0_addr_b, r0_wdata,
    input  r1_req, r1_lock, r1_we_a, r1_we_b, r1_addr_a, r1_addr_b, r1_wdata,
    output r0_gnt, r0_rvalid, r0_rdata_a, r0_rdata_b,
    output r1_gnt, r1_rvalid, r1_rdata_a, r1_rdata_b,
    output ram_wr_en_a, ram_wr_en_b, ram_addr_a, ram_addr_b, ram_wdata,
    input  ram_rdata_a, ram_rdata_b
  );

  modport master (
    output r0_req, r0_lock, r0_we_a, r0_we_b, r0_addr_a, r0_addr_b, r0_wdata,
    output r1_req, r1_lock, r1_we_a, r1_we_b, r1_addr_a, r1_addr_b, r1_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata_a, r0_rdata_b,
    input  r1_gnt, r1_rvalid, r1_rdata_a, r1_rdata_b,
    input  ram_wr_en_a, ram_wr_en_b, ram_addr_a, ram_addr_b, ram_wdata,
    output ram_rdata_a, ram_rdata_b
  );
endinterface

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// Two-deep read tag shift register; marks which requester owns the RAM read data
// arriving two cycles after its grant.
module rd_tag_pipe
  import frodo_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_vld,
  input  req_id_t            i_id,
  input  logic               i_is_read,
  output logic [NUM_REQ-1:0] o_rvalid
);
  rd_tag_t r_pipe [1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe[1] <= '0;
      r_pipe[2] <= '0;
    end else begin
      r_pipe[1] <= '{vld: i_vld, id: i_id, is_read: i_is_read};
      r_pipe[2] <= r_pipe[1];
    end
  end

  always_comb begin
    o_rvalid = '0;
    if (r_pipe[2].vld && r_pipe[2].is_read) o_rvalid[r_pipe[2].id] = 1'b1;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded lock sharing one dual-port RAM between the
// control engine (r0) and the host load/store path (r1).
module ram_port_arbiter
  import frodo_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_HOLD   = 64
)(
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD);

  owner_e                r_owner, w_owner_nxt;
  req_id_t               r_last, w_last_nxt, w_gnt_id, w_own_id;
  logic [HW-1:0]         r_hold_cnt, w_hold_nxt;
  logic [NUM_REQ-1:0]    w_req, w_rvalid;
  logic                  w_gnt_any, w_locked, w_force, w_sel_lock;
  logic                  w_sel_we_a, w_sel_we_b;
  logic [ADDR_WIDTH-1:0] w_sel_addr_a, w_sel_addr_b, r_addr_a, r_addr_b;
  logic [DATA_WIDTH-1:0] w_sel_wdata, r_wdata;
  logic                  r_wr_en_a, r_wr_en_b;

  assign w_req = {bus.r1_req, bus.r0_req};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= OWN_NONE;
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // An owner that drops req falls through to plain round-robin in the same cycle.
  always_comb begin
    w_own_id    = req_id_t'(r_owner == OWN_R1);
    w_locked    = (r_owner != OWN_NONE) && w_req[w_own_id];
    w_force     = w_locked && w_req[~w_own_id] && (r_hold_cnt == HW'(MAX_HOLD - 1));
    w_gnt_any   = |w_req;
    if (w_locked)           w_gnt_id = w_force ? ~w_own_id : w_own_id;
    else if (&w_req)        w_gnt_id = ~r_last;
    else                    w_gnt_id = w_req[1];
    w_sel_lock  = w_gnt_id ? bus.r1_lock : bus.r0_lock;
    w_owner_nxt = OWN_NONE;
    w_last_nxt  = r_last;
    w_hold_nxt  = '0;
    if (w_gnt_any) begin
      w_last_nxt = w_gnt_id;
      if (w_sel_lock) w_owner_nxt = id2owner(w_gnt_id);
      if (w_sel_lock && w_locked && !w_force && w_req[~w_gnt_id])
        w_hold_nxt = r_hold_cnt + HW'(1);
    end
  end

  always_comb begin
    bus.r0_gnt   = w_gnt_any && !w_gnt_id;
    bus.r1_gnt   = w_gnt_any &&  w_gnt_id;
    w_sel_we_a   = w_gnt_id ? bus.r1_we_a   : bus.r0_we_a;
    w_sel_we_b   = w_gnt_id ? bus.r1_we_b   : bus.r0_we_b;
    w_sel_addr_a = w_gnt_id ? bus.r1_addr_a : bus.r0_addr_a;
    w_sel_addr_b = w_gnt_id ? bus.r1_addr_b : bus.r0_addr_b;
    w_sel_wdata  = w_gnt_id ? bus.r1_wdata  : bus.r0_wdata;
  end

  // Idle cycles only drop the write enables; address/data keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en_a <= 1'b0;
      r_wr_en_b <= 1'b0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_wdata   <= '0;
    end else if (w_gnt_any) begin
      r_wr_en_a <= w_sel_we_a;
      r_wr_en_b <= w_sel_we_b;
      r_addr_a  <= w_sel_addr_a;
      r_addr_b  <= w_sel_addr_b;
      r_wdata   <= w_sel_wdata;
    end else begin
      r_wr_en_a <= 1'b0;
      r_wr_en_b <= 1'b0;
    end
  end

  assign bus.ram_wr_en_a = r_wr_en_a;
  assign bus.ram_wr_en_b = r_wr_en_b;
  assign bus.ram_addr_a  = r_addr_a;
  assign bus.ram_addr_b  = r_addr_b;
  assign bus.ram_wdata   = r_wdata;

  rd_tag_pipe u_tag (
    .clk       (clk),
    .rst       (rst),
    .i_vld     (w_gnt_any),
    .i_id      (w_gnt_id),
    .i_is_read (!(w_sel_we_a && w_sel_we_b)),
    .o_rvalid  (w_rvalid)
  );

  assign bus.r0_rvalid  = w_rvalid[0];
  assign bus.r1_rvalid  = w_rvalid[1];
  assign bus.r0_rdata_a = w_rvalid[0] ? bus.ram_rdata_a : '0;
  assign bus.r0_rdata_b = w_rvalid[0] ? bus.ram_rdata_b : '0;
  assign bus.r1_rdata_a = w_rvalid[1] ? bus.ram_rdata_a : '0;
  assign bus.r1_rdata_b = w_rvalid[1] ? bus.ram_rdata_b : '0;
endmodule
